// File: rtl/mdc_stream_writer_if.sv
// Stream-side bundle for mdc_stream_writer: upstream valid/ready words in,
// MDC network data/wr/full port out.
interface mdc_stream_writer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_wr;
  logic              out_full;

  modport master (
    input  s_data, s_valid, out_full,
    output s_ready, out_data, out_wr
  );

  modport slave (
    output s_data, s_valid, out_full,
    input  s_ready, out_data, out_wr
  );
endinterface

// File: rtl/mdc_stream_writer.sv
// Writes len_words stream words into one MDC network input port via a 2-entry FIFO.
// Optional MDC_WRITER_STALL_CNT_EN adds a saturating back-pressure cycle counter (stall_cnt).
module mdc_stream_writer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] word_cnt,
`ifdef MDC_WRITER_STALL_CNT_EN
  output logic [LEN_W-1:0] stall_cnt,
`endif
  mdc_stream_writer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [LEN_W-1:0] ONE = 1;

  state_t                       state, state_nxt;
  logic [LEN_W-1:0]             len_q, len_nxt;
  logic [LEN_W-1:0]             acc_cnt, acc_nxt;
  logic [1:0][DATA_W-1:0]       mem;
  logic [DATA_W-1:0]            last_q;
  logic                         rd_ptr, wr_ptr;
  logic [1:0]                   cnt, cnt_nxt;
  logic                         s_ready_q, rdy_nxt;
  logic                         push, pop, start_acc;

  assign start_acc = (state == IDLE) && start;
  assign push      = bus.s_valid && s_ready_q;
  // Write strobe follows out_full combinationally so a word never lands on a full port.
  assign pop       = (cnt != 2'd0) && !bus.out_full;

  assign bus.s_ready  = s_ready_q;
  assign bus.out_wr   = pop;
  assign bus.out_data = (cnt != 2'd0) ? mem[rd_ptr] : last_q;
  assign busy         = (state == RUN);
  assign done         = (state == DONE);

  always_comb begin
    state_nxt = state;
    len_nxt   = start_acc ? len_words : len_q;
    acc_nxt   = start_acc ? '0 : (push ? acc_cnt + ONE : acc_cnt);
    cnt_nxt   = 2'(cnt + {1'b0, push} - {1'b0, pop});
    case (state)
      IDLE: if (start) state_nxt = (len_words == '0) ? DONE : RUN;
      RUN:  if (pop && (word_cnt + ONE == len_q)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Registered ready: look at post-edge occupancy so a push can never overflow.
    rdy_nxt = (state_nxt == RUN) && (cnt_nxt != 2'd2) && (acc_nxt < len_nxt);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      acc_cnt   <= '0;
      word_cnt  <= '0;
      cnt       <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      mem       <= '0;
      last_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_q     <= len_nxt;
      acc_cnt   <= acc_nxt;
      cnt       <= cnt_nxt;
      s_ready_q <= rdy_nxt;
      if (start_acc)  word_cnt <= '0;
      else if (pop)   word_cnt <= word_cnt + ONE;
      if (push) begin
        mem[wr_ptr] <= bus.s_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
    end
  end

`ifdef MDC_WRITER_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset || start_acc)
      stall_cnt <= '0;
    else if ((state == RUN) && (cnt != 2'd0) && bus.out_full && (stall_cnt != '1))
      stall_cnt <= stall_cnt + ONE;
  end
`endif

endmodule
